// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the SPARC load/store unit. Holds the
//                operation codes, memory access sizes, trap codes, the FSM
//                state encoding and a helper that returns the low-address
//                alignment mask for a given access size.
//  Revision    : 1.0  - initial release
// ============================================================================
package lsu_pkg;

    // Operation codes presented on req_op
    localparam logic [3:0] LDUB = 4'b0000;
    localparam logic [3:0] LDSB = 4'b0001;
    localparam logic [3:0] LDUH = 4'b0010;
    localparam logic [3:0] LDSH = 4'b0011;
    localparam logic [3:0] LD   = 4'b0100;
    localparam logic [3:0] LDD  = 4'b0101;
    localparam logic [3:0] STB  = 4'b1000;
    localparam logic [3:0] STH  = 4'b1001;
    localparam logic [3:0] ST   = 4'b1010;
    localparam logic [3:0] STD  = 4'b1011;

    // Memory access size encoding on mem_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Trap codes reported on resp_trap
    localparam logic [1:0] c_trap_none     = 2'b00;
    localparam logic [1:0] c_trap_misalign = 2'b01;
    localparam logic [1:0] c_trap_illegal  = 2'b10;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_acc0 = 2'b01;
    localparam logic [1:0] c_st_acc1 = 2'b10;
    localparam logic [1:0] c_st_resp = 2'b11;

    // Low address bits that must be zero for an access of this size.
    // A doubleword access covers eight bytes even though each of its two
    // memory beats is word sized.
    function automatic logic [2:0] size_mask(input logic [1:0] size,
                                             input logic       is_double);
        logic [2:0] mask;
        if (is_double) begin
            mask = 3'b111;
        end else begin
            case (size)
                SZ_HALF: mask = 3'b001;
                SZ_WORD: mask = 3'b011;
                default: mask = 3'b000;
            endcase
        end
        return mask;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_decode
//  Description : Combinational request decoder for the load/store unit.
//                Translates an operation code and the low address bits into
//                memory access attributes and request-level error flags.
//  Ports       : i_op         operation code
//                i_addr_lo    effective address bits [2:0]
//                o_size       access size per beat (byte/half/word)
//                o_se         sign-extend select for loads
//                o_rw         1 = store, 0 = load
//                o_is_double  two word beats (LDD/STD)
//                o_misaligned address low bits violate the natural alignment
//                o_illegal    operation code not recognised
//  Revision    : 1.0  - initial release
// ============================================================================
module lsu_decode
    import lsu_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [2:0] i_addr_lo,
    output logic [1:0] o_size,
    output logic       o_se,
    output logic       o_rw,
    output logic       o_is_double,
    output logic       o_misaligned,
    output logic       o_illegal
);

    always_comb begin
        o_size      = SZ_BYTE;
        o_se        = 1'b0;
        o_rw        = 1'b0;
        o_is_double = 1'b0;
        o_illegal   = 1'b0;
        case (i_op)
            LDUB: begin
            end
            LDSB: begin
                o_se = 1'b1;
            end
            LDUH: begin
                o_size = SZ_HALF;
            end
            LDSH: begin
                o_size = SZ_HALF;
                o_se   = 1'b1;
            end
            LD: begin
                o_size = SZ_WORD;
            end
            LDD: begin
                o_size      = SZ_WORD;
                o_is_double = 1'b1;
            end
            STB: begin
                o_rw = 1'b1;
            end
            STH: begin
                o_size = SZ_HALF;
                o_rw   = 1'b1;
            end
            ST: begin
                o_size = SZ_WORD;
                o_rw   = 1'b1;
            end
            STD: begin
                o_size      = SZ_WORD;
                o_rw        = 1'b1;
                o_is_double = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    // Illegal ops decode as byte size, so their mask is zero and they never
    // also flag as misaligned.
    assign o_misaligned = |(i_addr_lo & size_mask(o_size, o_is_double));

endmodule : lsu_decode
`default_nettype wire

// File: rtl/sparc_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sparc_load_store_unit
//  Description : MEM-stage initiator for a byte-addressed data memory.
//                Accepts one load/store per transaction, checks alignment,
//                sequences one or two memory accesses (LDD/STD are split into
//                two word beats at addr and addr+4) and returns load data or
//                a trap code over a valid/ready response channel.
//  Ports       : clk, reset                  clock, sync active-high reset
//                req_valid/req_ready         request handshake
//                req_op/req_addr             operation and byte address
//                req_wdata0/req_wdata1       store data (word 0 / word 1)
//                resp_valid/resp_ready       response handshake
//                resp_rdata0/resp_rdata1     load data (word 0 / word 1)
//                resp_trap                   00 none, 01 misaligned, 10 illegal
//                mem_enable/mem_rw/mem_se    memory control (all registered)
//                mem_size/mem_addr/mem_din   memory access attributes/data
//                mem_dout                    memory read data (combinational)
//  Options     : LSU_ALIGN_TRAP_EN - when defined, misaligned requests trap
//                with code 01 and never touch memory. When undefined, the
//                address low bits are cleared to the natural alignment and
//                the access proceeds.
//  Revision    : 1.0  - initial release
// ============================================================================
module sparc_load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata0,
    output logic [DATA_W-1:0] resp_rdata1,
    output logic [1:0]        resp_trap,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic              mem_se,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W-1:0] c_word_step = ADDR_W'(4);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0]        w_size;
    logic              w_se;
    logic              w_rw;
    logic              w_is_double;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_trap_misaligned;
    logic [ADDR_W-1:0] w_eff_addr;

    lsu_decode u_decode (
        .i_op         (req_op),
        .i_addr_lo    (req_addr[2:0]),
        .o_size       (w_size),
        .o_se         (w_se),
        .o_rw         (w_rw),
        .o_is_double  (w_is_double),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

`ifdef LSU_ALIGN_TRAP_EN
    assign w_trap_misaligned = w_misaligned;
    assign w_eff_addr        = req_addr;
`else
    // Misaligned addresses are silently rounded down to the access size;
    // aligned addresses already have the masked bits clear.
    logic [ADDR_W-1:0] w_lo_mask;

    assign w_lo_mask         = {{(ADDR_W-3){1'b0}}, size_mask(w_size, w_is_double)};
    assign w_trap_misaligned = 1'b0;
    assign w_eff_addr        = w_misaligned ? (req_addr & ~w_lo_mask) : req_addr;
`endif

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_double;
    logic [DATA_W-1:0] r_wdata1;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [1:0]        r_trap;
    logic              r_mem_enable;
    logic              r_mem_rw;
    logic              r_mem_se;
    logic [1:0]        r_mem_size;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_double     <= 1'b0;
            r_wdata1     <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_trap       <= c_trap_none;
            r_mem_enable <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_se     <= 1'b0;
            r_mem_size   <= SZ_BYTE;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        // Stores and traps report zero data, so clear the
                        // previous response here rather than per path.
                        r_req_ready <= 1'b0;
                        r_rdata0    <= '0;
                        r_rdata1    <= '0;
                        r_double    <= w_is_double;
                        r_wdata1    <= req_wdata1;
                        if (w_illegal) begin
                            r_trap       <= c_trap_illegal;
                            r_resp_valid <= 1'b1;
                            r_state      <= c_st_resp;
                        end else if (w_trap_misaligned) begin
                            r_trap       <= c_trap_misalign;
                            r_resp_valid <= 1'b1;
                            r_state      <= c_st_resp;
                        end else begin
                            r_trap       <= c_trap_none;
                            r_mem_enable <= 1'b1;
                            r_mem_rw     <= w_rw;
                            r_mem_se     <= w_se;
                            r_mem_size   <= w_size;
                            r_mem_addr   <= w_eff_addr;
                            r_mem_din    <= req_wdata0;
                            r_state      <= c_st_acc0;
                        end
                    end
                end

                c_st_acc0: begin
                    if (!r_mem_rw) begin
                        r_rdata0 <= mem_dout;
                    end
                    if (r_double) begin
                        // Second beat of a doubleword: always a plain word
                        r_mem_addr <= r_mem_addr + c_word_step;
                        r_mem_size <= SZ_WORD;
                        r_mem_se   <= 1'b0;
                        r_mem_din  <= r_wdata1;
                        r_state    <= c_st_acc1;
                    end else begin
                        r_mem_enable <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= c_st_resp;
                    end
                end

                c_st_acc1: begin
                    if (!r_mem_rw) begin
                        r_rdata1 <= mem_dout;
                    end
                    r_mem_enable <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= c_st_resp;
                end

                c_st_resp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= c_st_idle;
                    end
                end

                default: begin
                    r_mem_enable <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata0 = r_rdata0;
    assign resp_rdata1 = r_rdata1;
    assign resp_trap   = r_trap;
    assign mem_enable  = r_mem_enable;
    assign mem_rw      = r_mem_rw;
    assign mem_se      = r_mem_se;
    assign mem_size    = r_mem_size;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;

endmodule : sparc_load_store_unit
`default_nettype wire
